picorv32_ahb_bridge: RTL

Parametrised bridge between the picorv32 native memory handshake (`mem_valid`/`mem_ready`) and a single-master AHB-Lite bus. It is the successor to the fixed-function adapter.

---
 rtl/picorv_ahb_pkg.sv | 50 +++++
 rtl/picorv_ahb_wbuf.sv | 61 ++++++
 rtl/picorv32_ahb_bridge.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/picorv_ahb_pkg.sv
// Shared AHB-Lite constants, FSM state type, posted-write entry and strobe decode
// for the picorv32 AHB bridge.
package picorv_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10,
        ST_RESP = 2'b11
    } state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  size;
        logic [3:0]  prot;
    } wentry_t;

    typedef struct packed {
        logic [2:0] size;
        logic [1:0] offset;
    } size_off_t;

    // Irregular strobe patterns fall back to an aligned word write.
    function automatic size_off_t strb_decode(input logic [3:0] wstrb);
        size_off_t r;
        r.size   = HSIZE_WORD;
        r.offset = 2'd0;
        case (wstrb)
            4'b0011: begin r.size = HSIZE_HALF; r.offset = 2'd0; end
            4'b1100: begin r.size = HSIZE_HALF; r.offset = 2'd2; end
            4'b0001: begin r.size = HSIZE_BYTE; r.offset = 2'd0; end
            4'b0010: begin r.size = HSIZE_BYTE; r.offset = 2'd1; end
            4'b0100: begin r.size = HSIZE_BYTE; r.offset = 2'd2; end
            4'b1000: begin r.size = HSIZE_BYTE; r.offset = 2'd3; end
            default: begin r.size = HSIZE_WORD; r.offset = 2'd0; end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/picorv_ahb_wbuf.sv
// Posted-write FIFO: synchronous, power-of-two depth, wrap-around pointers with
// an occupancy count that drives full/empty.
module picorv_ahb_wbuf #(
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          push,
    input  picorv_ahb_pkg::wentry_t       wdata,
    input  logic                          pop,
    output picorv_ahb_pkg::wentry_t       rdata,
    output logic                          full,
    output logic                          empty
);
    import picorv_ahb_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wentry_t       mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/picorv32_ahb_bridge.sv
// picorv32 native memory port to single-master AHB-Lite bridge.
// Define PICORV_AHB_POSTED_WRITE_EN to build the posted-write FIFO.
module picorv32_ahb_bridge #(
    parameter int   ADDR_W     = 32,
    parameter int   WBUF_DEPTH = 4,
    parameter logic PROT_PRIV  = 1'b1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_valid,
    input  logic              mem_instr,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_wstrb,
    output logic              mem_ready,
    output logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [3:0]        hprot,
    output logic [31:0]       hwdata,
    input  logic [31:0]       hrdata,
    input  logic              hready,
    input  logic              hresp,
    output logic              bus_err,
    output logic [ADDR_W-1:0] err_addr
);
    import picorv_ahb_pkg::*;

    if (WBUF_DEPTH < 2 || (WBUF_DEPTH & (WBUF_DEPTH - 1)) != 0) begin : g_bad_wbuf_depth
        $error("WBUF_DEPTH must be a power of two and at least 2");
    end

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] haddr_q, haddr_d;
    logic              hwrite_q, hwrite_d;
    logic [2:0]        hsize_q, hsize_d;
    logic [3:0]        hprot_q, hprot_d;
    logic [31:0]       hwdata_q, hwdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              mem_ready_q, mem_ready_d;
    logic              bus_err_q, bus_err_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic              posted_q, posted_d;

    logic        is_write;
    size_off_t   so;
    logic [31:0] req_addr32;
    logic [2:0]  req_size;
    logic [3:0]  req_prot;
    logic        req_direct;
    logic        wb_push, wb_empty;
    wentry_t     wb_head;
    logic        unused_addr_lsbs;

    assign is_write         = |mem_wstrb;
    assign so               = strb_decode(mem_wstrb);
    assign req_addr32       = {mem_addr[31:2], is_write ? so.offset : 2'b00};
    assign req_size         = is_write ? so.size : HSIZE_WORD;
    assign req_prot         = {2'b00, PROT_PRIV, ~mem_instr};
    assign unused_addr_lsbs = ^mem_addr[1:0];

`ifdef PICORV_AHB_POSTED_WRITE_EN
    logic    wb_full, wb_pop;
    wentry_t wb_in;

    // Writes are acked from the FIFO; the held mem_valid during the ack cycle must not push again.
    assign wb_push    = mem_valid && is_write && !mem_ready_q && !wb_full;
    assign wb_pop     = (state_q == ST_DATA) && hready && posted_q;
    assign req_direct = mem_valid && !is_write && !mem_ready_q && wb_empty;
    assign wb_in      = '{addr: req_addr32, wdata: mem_wdata, size: req_size, prot: req_prot};

    picorv_ahb_wbuf #(
        .DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .clk    (clk),
        .resetn (resetn),
        .push   (wb_push),
        .wdata  (wb_in),
        .pop    (wb_pop),
        .rdata  (wb_head),
        .full   (wb_full),
        .empty  (wb_empty)
    );
`else
    assign wb_push    = 1'b0;
    assign wb_empty   = 1'b1;
    assign wb_head    = '0;
    assign req_direct = mem_valid && !mem_ready_q;
`endif

    always_comb begin
        state_d     = state_q;
        haddr_d     = haddr_q;
        hwrite_d    = hwrite_q;
        hsize_d     = hsize_q;
        hprot_d     = hprot_q;
        hwdata_d    = hwdata_q;
        rdata_d     = rdata_q;
        posted_d    = posted_q;
        err_addr_d  = err_addr_q;
        bus_err_d   = 1'b0;
        mem_ready_d = wb_push;
        case (state_q)
            ST_IDLE: begin
                // Buffered writes drain before any new direct request, keeping program order.
                if (!wb_empty) begin
                    haddr_d  = wb_head.addr[ADDR_W-1:0];
                    hwrite_d = 1'b1;
                    hsize_d  = wb_head.size;
                    hprot_d  = wb_head.prot;
                    hwdata_d = wb_head.wdata;
                    posted_d = 1'b1;
                    state_d  = ST_ADDR;
                end else if (req_direct) begin
                    haddr_d  = req_addr32[ADDR_W-1:0];
                    hwrite_d = is_write;
                    hsize_d  = req_size;
                    hprot_d  = req_prot;
                    hwdata_d = mem_wdata;
                    posted_d = 1'b0;
                    state_d  = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (hready) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (hready) begin
                    rdata_d     = hresp ? 32'h0 : hrdata;
                    mem_ready_d = wb_push || !posted_q;
                    if (hresp) begin
                        bus_err_d  = 1'b1;
                        err_addr_d = haddr_q;
                    end
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            hsize_q     <= HSIZE_WORD;
            hprot_q     <= {2'b00, PROT_PRIV, 1'b1};
            hwdata_q    <= '0;
            rdata_q     <= '0;
            posted_q    <= 1'b0;
            err_addr_q  <= '0;
            bus_err_q   <= 1'b0;
            mem_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            hprot_q     <= hprot_d;
            hwdata_q    <= hwdata_d;
            rdata_q     <= rdata_d;
            posted_q    <= posted_d;
            err_addr_q  <= err_addr_d;
            bus_err_q   <= bus_err_d;
            mem_ready_q <= mem_ready_d;
        end
    end

    assign htrans    = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign hburst    = HBURST_SINGLE;
    assign haddr     = haddr_q;
    assign hwrite    = hwrite_q;
    assign hsize     = hsize_q;
    assign hprot     = hprot_q;
    assign hwdata    = hwdata_q;
    assign mem_ready = mem_ready_q;
    assign mem_rdata = rdata_q;
    assign bus_err   = bus_err_q;
    assign err_addr  = err_addr_q;

endmodule
